// File: rtl/writeback.sv
// Writeback stage: register file, overflow register, condition flags, PC and redirect flush.
// Optional combinational write bypass is built when WB_BYPASS_EN is defined.
module writeback #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] PC_RESET     = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Valid,
  input  logic [31:0]       Result,
  input  logic [31:0]       Ovf,
  input  logic [3:0]        Rc,
  input  logic [2:0]        Cond,
  input  logic              Cmp,
  output logic [13:0][31:0] r,
  output logic [31:0]       overflow,
  output logic [31:0]       pc,
  output logic              flush,
  output logic              fwd_valid,
  output logic [3:0]        fwd_reg,
  output logic [31:0]       fwd_data
);

  typedef enum logic [2:0] {
    C_AL = 3'd0,
    C_NV = 3'd1,
    C_EQ = 3'd2,
    C_NE = 3'd3,
    C_MI = 3'd4,
    C_PL = 3'd5,
    C_GT = 3'd6,
    C_LE = 3'd7
  } cond_e;

  localparam logic [3:0] RC_PC  = 4'hE;
  localparam logic [3:0] RC_OVF = 4'hF;

  logic [2:0] count;
  logic       flag_z;
  logic       flag_n;
  logic       accept;
  logic       cond_true;
  logic       commit;
  logic       wr_gpr;
  logic       wr_ovf;
  logic       redirect;
  cond_e      cond;

  assign cond  = cond_e'(Cond);
  assign flush = (count != '0);

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      C_AL: cond_true = 1'b1;
      C_NV: cond_true = 1'b0;
      C_EQ: cond_true = flag_z;
      C_NE: cond_true = !flag_z;
      C_MI: cond_true = flag_n;
      C_PL: cond_true = !flag_n;
      C_GT: cond_true = !flag_n && !flag_z;
      C_LE: cond_true = flag_n || flag_z;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    accept   = Valid && !flush;
    commit   = accept && !Cmp && cond_true;
    wr_gpr   = commit && (Rc < 4'd14);
    wr_ovf   = commit && (Rc == RC_OVF);
    redirect = commit && (Rc == RC_PC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r        <= '0;
      overflow <= '0;
      pc       <= PC_RESET;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      count    <= '0;
    end else begin
      // Compares only touch flags; register/overflow/PC writes need a true condition.
      if (accept && Cmp) begin
        flag_z <= (Result == '0);
        flag_n <= Result[31];
      end
      for (int unsigned i = 0; i < 14; i++) begin
        if (wr_gpr && (Rc == 4'(i))) r[i] <= Result;
      end
      if (wr_gpr)      overflow <= Ovf;
      else if (wr_ovf) overflow <= Result;
      if (redirect) begin
        pc    <= Result;
        count <= 3'(FLUSH_CYCLES);
      end else begin
        pc <= pc + 32'd1;
        if (count != '0) count <= count - 3'd1;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_valid = rst && wr_gpr;
  assign fwd_reg   = fwd_valid ? Rc : '0;
  assign fwd_data  = fwd_valid ? Result : '0;
`else
  assign fwd_valid = 1'b0;
  assign fwd_reg   = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_writeback.sv
// Table-driven bench for writeback: hand-computed expectations queued at drive time, checked after each edge.
module tb_writeback;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              Valid;
  logic [31:0]       Result;
  logic [31:0]       Ovf;
  logic [3:0]        Rc;
  logic [2:0]        Cond;
  logic              Cmp;
  logic [13:0][31:0] r;
  logic [31:0]       overflow;
  logic [31:0]       pc;
  logic              flush;
  logic              fwd_valid;
  logic [3:0]        fwd_reg;
  logic [31:0]       fwd_data;

  int tests  = 0;
  int failed = 0;

  writeback #(.FLUSH_CYCLES(2), .PC_RESET(32'h0)) dut (
    .clk(clk), .rst(rst), .Valid(Valid), .Result(Result), .Ovf(Ovf), .Rc(Rc),
    .Cond(Cond), .Cmp(Cmp), .r(r), .overflow(overflow), .pc(pc), .flush(flush),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
    $fatal(1);
  end

  typedef struct {
    bit          valid;
    bit          cmp;
    logic [2:0]  cond;
    logic [3:0]  rc;
    logic [31:0] result;
    logic [31:0] ovf;
    logic [31:0] e_pc;
    bit          e_flush;
    int          idx;
    logic [31:0] e_r;
    logic [31:0] e_ovf;
    bit          e_fv;
  } vec_t;

  vec_t tbl[23];
  vec_t sb[$];
  vec_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(bit valid, bit cmp, logic [2:0] cond, logic [3:0] rc,
                             logic [31:0] result, logic [31:0] ovf, logic [31:0] e_pc,
                             bit e_flush, int idx, logic [31:0] e_r, logic [31:0] e_ovf,
                             bit e_fv);
    vec_t t;
    t.valid = valid; t.cmp = cmp; t.cond = cond; t.rc = rc; t.result = result;
    t.ovf = ovf; t.e_pc = e_pc; t.e_flush = e_flush; t.idx = idx; t.e_r = e_r;
    t.e_ovf = e_ovf; t.e_fv = e_fv;
    return t;
  endfunction

  initial begin
    //           vld cmp cnd rc     result        ovf         pc            fl idx r             ovf      fv
    tbl[0]  = v(1, 0, 0, 4'd5,  32'hDEADBEEF, 32'h7,  32'd4,        0, 5,  32'hDEADBEEF, 32'h7,  1);
    tbl[1]  = v(1, 1, 0, 4'd5,  32'h0,        32'h9,  32'd5,        0, 5,  32'hDEADBEEF, 32'h7,  0);
    tbl[2]  = v(1, 0, 2, 4'd1,  32'h9,        32'h11, 32'd6,        0, 1,  32'h9,        32'h11, 1);
    tbl[3]  = v(1, 0, 3, 4'd1,  32'h4,        32'h22, 32'd7,        0, 1,  32'h9,        32'h11, 0);
    tbl[4]  = v(1, 1, 0, 4'd1,  32'h80000000, 32'h0,  32'd8,        0, 1,  32'h9,        32'h11, 0);
    tbl[5]  = v(1, 0, 4, 4'd2,  32'hA,        32'h1,  32'd9,        0, 2,  32'hA,        32'h1,  1);
    tbl[6]  = v(1, 0, 6, 4'd2,  32'hB,        32'h5,  32'd10,       0, 2,  32'hA,        32'h1,  0);
    tbl[7]  = v(1, 0, 7, 4'd13, 32'h1313,     32'h2,  32'd11,       0, 13, 32'h1313,     32'h2,  1);
    tbl[8]  = v(1, 0, 1, 4'd3,  32'h33,       32'h6,  32'd12,       0, 3,  32'h0,        32'h2,  0);
    tbl[9]  = v(0, 0, 0, 4'd3,  32'h44,       32'h6,  32'd13,       0, 3,  32'h0,        32'h2,  0);
    tbl[10] = v(1, 0, 0, 4'hF,  32'h55,       32'h99, 32'd14,       0, 13, 32'h1313,     32'h55, 0);
    tbl[11] = v(1, 1, 0, 4'd0,  32'h5,        32'h0,  32'd15,       0, 0,  32'h0,        32'h55, 0);
    tbl[12] = v(1, 0, 5, 4'd0,  32'h77,       32'h3,  32'd16,       0, 0,  32'h77,       32'h3,  1);
    tbl[13] = v(1, 0, 6, 4'd4,  32'h66,       32'h4,  32'd17,       0, 4,  32'h66,       32'h4,  1);
    tbl[14] = v(1, 0, 0, 4'hE,  32'h100,      32'h5,  32'h100,      1, 4,  32'h66,       32'h4,  0);
    tbl[15] = v(1, 0, 0, 4'd2,  32'hBAD,      32'hEE, 32'h101,      1, 2,  32'hA,        32'h4,  0);
    tbl[16] = v(1, 0, 0, 4'd2,  32'hBAD,      32'hEE, 32'h102,      0, 2,  32'hA,        32'h4,  0);
    tbl[17] = v(1, 0, 0, 4'd2,  32'hC,        32'h8,  32'h103,      0, 2,  32'hC,        32'h8,  1);
    tbl[18] = v(1, 0, 0, 4'hE,  32'hFFFFFFFE, 32'h0,  32'hFFFFFFFE, 1, 2,  32'hC,        32'h8,  0);
    tbl[19] = v(0, 0, 0, 4'd0,  32'h0,        32'h0,  32'hFFFFFFFF, 1, 0,  32'h77,       32'h8,  0);
    tbl[20] = v(0, 0, 0, 4'd0,  32'h0,        32'h0,  32'h0,        0, 0,  32'h77,       32'h8,  0);
    tbl[21] = v(1, 1, 0, 4'hE,  32'h200,      32'h0,  32'h1,        0, 0,  32'h77,       32'h8,  0);
    tbl[22] = v(1, 0, 0, 4'hE,  32'h300,      32'h0,  32'h300,      1, 0,  32'h77,       32'h8,  0);

    rst = 1'b0; Valid = 1'b0; Result = '0; Ovf = '0; Rc = '0; Cond = '0; Cmp = 1'b0;
    #2;
    chk("reset_pc", pc, 32'h0);
    chk("reset_ovf", overflow, 32'h0);
    chk("reset_flush", 32'(flush), 32'h0);
    chk("reset_fwd_valid", 32'(fwd_valid), 32'h0);

    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_pc", pc, 32'd3);
    chk("idle_flush", 32'(flush), 32'h0);
    for (int i = 0; i < 14; i++) chk($sformatf("idle_r%0d", i), r[i], 32'h0);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      Valid = tbl[i].valid; Cmp = tbl[i].cmp; Cond = tbl[i].cond; Rc = tbl[i].rc;
      Result = tbl[i].result; Ovf = tbl[i].ovf;
      sb.push_back(tbl[i]);
      #1;
      chk($sformatf("v%0d_fwd_valid", i), 32'(fwd_valid), 32'(BYP & tbl[i].e_fv));
      chk($sformatf("v%0d_fwd_reg", i), 32'(fwd_reg),
          (BYP & tbl[i].e_fv) ? 32'(tbl[i].rc) : 32'h0);
      chk($sformatf("v%0d_fwd_data", i), fwd_data,
          (BYP & tbl[i].e_fv) ? tbl[i].result : 32'h0);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_pc", i), pc, e.e_pc);
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(e.e_flush));
      chk($sformatf("v%0d_r%0d", i, e.idx), r[e.idx], e.e_r);
      chk($sformatf("v%0d_ovf", i), overflow, e.e_ovf);
    end

    // Reset asserted mid-flush, with a writable instruction present.
    Valid = 1'b1; Cmp = 1'b0; Cond = 3'd0; Rc = 4'd5; Result = 32'h1234; Ovf = 32'h1;
    #2;
    rst = 1'b0;
    #1;
    chk("rstflush_flush", 32'(flush), 32'h0);
    chk("rstflush_pc", pc, 32'h0);
    chk("rstflush_r0", r[0], 32'h0);
    chk("rstflush_r13", r[13], 32'h0);
    chk("rstflush_ovf", overflow, 32'h0);
    chk("rstflush_fwd_valid", 32'(fwd_valid), 32'h0);
    chk("rstflush_fwd_data", fwd_data, 32'h0);
    @(negedge clk);
    Valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_pc", pc, 32'h1);
    chk("postrst_flush", 32'(flush), 32'h0);
    chk("postrst_r5", r[5], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, number of cycles younger instructions are squashed after a PC redirect (legal range 1-7).
REQ-002 Parameter: PC_RESET, default 32'h0, PC value loaded at reset.
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  reset; asynchronous and active-low.
REQ-005 Port: Valid  in  1  execute-stage result present this cycle.
REQ-006 Port: Result  in  32  ALU result.
REQ-007 Port: Ovf  in  32  ALU overflow/high word.
REQ-008 Port: Rc  in  4  destination: 0-13 general register, E = PC, F = overflow register.
REQ-009 Port: Cond  in  3  execution condition.
REQ-010 Port: Cmp  in  1  compare instruction; updates flags only.
REQ-011 Port: r  out  14x32  register file contents, read by decode.
REQ-012 Port: overflow  out  32  overflow register.
REQ-013 Port: pc  out  32  program counter.
REQ-014 Port: flush  out  1  high while younger pipeline contents are being squashed.
REQ-015 Port: fwd_valid, fwd_reg[3:0], fwd_data[31:0]  out  bypass of the write being committed this cycle (see Configuration).

Function
REQ-016 Input is accepted only when Valid=1 and flush=0; otherwise it is squashed, with no state change except the PC increment.
REQ-017 Accepted Cmp=1: Z<=(Result==0) and N<=Result[31]; Cond is ignored; no register, overflow or PC write.
REQ-018 Condition truth, using flags before this cycle's update: 0 always, 1 never, 2 Z, 3 !Z, 4 N, 5 !N, 6 !N&!Z, 7 N|Z.
REQ-019 Accepted Cmp=0 with a false condition: no architectural effect.
REQ-020 Accepted Cmp=0 with a true condition and Rc<=13: r[Rc]<=Result and overflow<=Ovf, in the same edge.
REQ-021 Accepted Cmp=0 with a true condition and Rc=F: overflow<=Result; Ovf is discarded.
REQ-022 Accepted Cmp=0 with a true condition and Rc=E (redirect): pc<=Result; flush is asserted from the next cycle for exactly FLUSH_CYCLES cycles.
REQ-023 When no redirect occurs, pc<=pc+1 every cycle, including during flush; 32'hFFFFFFFF wraps to 0.
REQ-024 Flush is driven by a down-counter loaded with FLUSH_CYCLES on redirect; flush=(count!=0).
REQ-025 A redirect cannot occur while flush=1 because the input is squashed (REQ-016).
REQ-026 Write latency is one cycle: a value written at edge N is visible on r at edge N.
REQ-027 The decode stage receives r combinationally from the registers; there is no read-during-write priority inside this block.

Reset
REQ-028 rst=0 asynchronously forces: r[0..13]=0, overflow=0, pc=PC_RESET, Z=0, N=0, flush count=0, fwd_valid=0, fwd_reg=0, fwd_data=0.
REQ-029 Reset asserted mid-flush clears flush immediately; the first edge after release increments pc from PC_RESET.

Configuration
REQ-030 With WB_BYPASS_EN defined: for an accepted, true, non-Cmp instruction with Rc<=13, fwd_valid=1, fwd_reg=Rc and fwd_data=Result, combinationally in the same cycle; otherwise these outputs are 0.
REQ-031 Without WB_BYPASS_EN: fwd_valid, fwd_reg and fwd_data are tied to 0; the ports remain present.

Verification
REQ-032 Reset: release rst; idle 3 cycles -> pc=3, all r=0, flush=0.
REQ-033 Write: Valid, Cmp=0, Cond=0, Rc=5, Result=32'hDEADBEEF, Ovf=7 -> next cycle r[5]=DEADBEEF and overflow=7; with macro defined, fwd_valid=1 and fwd_reg=5 during the input cycle.
REQ-034 Compare/condition: Cmp, Result=0, then Cond=2, Rc=1, Result=9 -> r[1]=9; repeat with Cond=3 and Result=4 -> r[1] stays 9.
REQ-035 Redirect/squash: Rc=E, Cond=0, Result=32'h100 -> pc=100, flush high for 2 cycles; Rc=2 writes presented during flush leave r[2] unchanged; pc=102 when flush drops.
REQ-036 Corner cases: Rc=F with Result=32'h55 -> overflow=55; pc forced near 32'hFFFFFFFF by a redirect wraps to 0; rst pulsed during flush -> flush=0 immediately.
